memory_stage: RTL and testbench
===============================

# memory_stage

Memory-access stage of the five-stage pipelined CPU, between execute and writeback. It holds the EX/MEM pipeline register and drives the address, store data and write strobe to the data cache. It captures load data returned by the cache and forwards control and results to writeback through the MEM/WB register. It stalls the pipeline while the data cache is not ready.

## Interface
- No parameters; all widths fixed.
- `clk_i` in 1: single clock; all state updates on its rising edge.
- `rst_i` in 1: synchronous reset, active-high.
- `flush_i` in 1: clear the EX/MEM register (insert bubble).
- `stall_i` in 1: hold both pipeline registers.
- `mem_write_en_i` in 1: instruction is a store.
- `reg_write_en_i` in 1: instruction writes the register file.
- `forward_en_i` in 1: use `forward_data_i` as store data.
- `data_cache_valid_i` in 1: cache has completed the current access.
- `wb_sel_i` in 2: writeback select; `2'b01` = load.
- `write_reg_sel_i` in 5: destination register.
- `cout_i` in 32: carry/aux result.
- `result_i` in 32: ALU result; also the memory address.
- `read_data_2_i` in 32: store data from the register file.
- `forward_data_i` in 32: forwarded store data.
- `data_from_cache_i` in 32: load data from the cache.
- `reg_write_en_o`, `wb_sel_o`, `write_reg_sel_o`, `result_o`, `cout_o`: out, same widths as the inputs; MEM/WB copies.
- `read_data_o` out 32: registered load data.
- `wr_to_cache_o` out 1: cache write strobe.
- `data_to_cache_o` out 32: store data to the cache.
- `addr_to_cache_o` out 32: cache address.
- `stall_o` out 1: memory stage busy; combinational.

## Operation
- The EX/MEM register captures every input field. For store data it captures `forward_data_i` when `forward_en_i` is 1, otherwise `read_data_2_i`.
- Cache outputs come directly from EX/MEM:
  - `addr_to_cache_o` = EX/MEM result.
  - `data_to_cache_o` = EX/MEM store data.
  - `wr_to_cache_o` = EX/MEM mem_write_en.
- Access pending = EX/MEM mem_write_en, or EX/MEM wb_sel == `2'b01`.
- `stall_o` = access pending AND NOT `data_cache_valid_i`.
- The MEM/WB register captures from EX/MEM: reg_write_en, wb_sel, write_reg_sel, result and cout. It captures `read_data_o` from `data_from_cache_i`, every non-stalled cycle.
- Update priority each edge, highest first:
  1. `rst_i`: both registers to 0.
  2. `flush_i`: EX/MEM to 0. MEM/WB loads normally.
  3. `stall_i`: both registers hold.
  4. `stall_o`: EX/MEM holds. MEM/WB loads a bubble (all fields 0).
  5. Otherwise: both registers load.

## Timing
- Reset value of every output is 0, including `stall_o`, since the reset EX/MEM register has no access pending.
- Input to cache-side outputs: 1 edge.
- Input to `reg_write_en_o`, `wb_sel_o`, `write_reg_sel_o`, `result_o`, `cout_o`: 2 edges.
- `data_from_cache_i` to `read_data_o`: 1 edge.
- With `data_cache_valid_i` held at 1, `stall_o` never asserts. Throughput is one instruction per cycle.
- Flush and stall asserted together: flush wins, so EX/MEM clears.
- A sustained `stall_i` holds every output constant indefinitely, including the zeroed values left by a preceding flush.

## Configuration
- Macro `MEM_STORE_FORWARD_EN`.
- Defined: the store-data mux honours `forward_en_i`.
- Undefined: store data is always `read_data_2_i`. `forward_en_i` and `forward_data_i` are ignored.

## Test plan
- Pass-through: after reset, drive reg_write_en=1, wb_sel=2, write_reg_sel=0x13, result=0xDEADBEEF, cout=0x1. After 2 edges the outputs equal these values.
- Load data: `data_from_cache_i` = 0x12345678. After 1 edge `read_data_o` = 0x12345678.
- Store: mem_write_en=1, result=0x100, read_data_2=0xCAFEF00D. After 1 edge: wr_to_cache_o=1, addr_to_cache_o=0x100, data_to_cache_o=0xCAFEF00D. Drop mem_write_en; one edge later wr_to_cache_o=0.
- Flush then stall: with the store pending, pulse flush_i. Next edge all cache outputs are 0. Then hold stall_i for 20 cycles with nonzero inputs; the outputs stay 0.
- Forwarding (macro defined): forward_en=1, forward_data=0x55AA55AA, read_data_2=0x1. After 1 edge `data_to_cache_o` = 0x55AA55AA.
- Cache not ready: a store reaches EX/MEM with data_cache_valid_i=0.
  - `stall_o`=1; cache outputs hold; `reg_write_en_o` bubbles to 0.
  - Raising valid clears `stall_o` and the store retires.

Source files
------------

// File: rtl/memory_stage.sv
// memory_stage: memory-access stage of the five-stage pipeline.
// Holds the EX/MEM register, drives the data-cache request, and feeds
// writeback through the MEM/WB register. While a cache access is pending
// and the cache has not answered, EX/MEM holds and MEM/WB takes bubbles.
// Optional feature macro: MEM_STORE_FORWARD_EN (store-data forwarding mux).
module memory_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        stall_i,
  input  logic        mem_write_en_i,
  input  logic        reg_write_en_i,
  input  logic        forward_en_i,
  input  logic        data_cache_valid_i,
  input  logic [1:0]  wb_sel_i,
  input  logic [4:0]  write_reg_sel_i,
  input  logic [31:0] cout_i,
  input  logic [31:0] result_i,
  input  logic [31:0] read_data_2_i,
  input  logic [31:0] forward_data_i,
  input  logic [31:0] data_from_cache_i,
  output logic        reg_write_en_o,
  output logic [1:0]  wb_sel_o,
  output logic [4:0]  write_reg_sel_o,
  output logic [31:0] result_o,
  output logic [31:0] cout_o,
  output logic [31:0] read_data_o,
  output logic        wr_to_cache_o,
  output logic [31:0] data_to_cache_o,
  output logic [31:0] addr_to_cache_o,
  output logic        stall_o
);

  localparam logic [1:0] WB_SEL_LOAD = 2'b01;

  // EX/MEM register
  logic        r_ex_mem_write_en;
  logic        r_ex_reg_write_en;
  logic [1:0]  r_ex_wb_sel;
  logic [4:0]  r_ex_write_reg_sel;
  logic [31:0] r_ex_cout;
  logic [31:0] r_ex_result;
  logic [31:0] r_ex_store_data;

  // MEM/WB register
  logic        r_wb_reg_write_en;
  logic [1:0]  r_wb_sel;
  logic [4:0]  r_wb_write_reg_sel;
  logic [31:0] r_wb_result;
  logic [31:0] r_wb_cout;
  logic [31:0] r_wb_read_data;

  logic [31:0] w_store_data;
  logic        w_pending;
  logic        w_mem_stall;

`ifdef MEM_STORE_FORWARD_EN
  assign w_store_data = forward_en_i ? forward_data_i : read_data_2_i;
`else
  // Forwarding inputs are deliberately left unconnected in this build.
  logic w_unused_fwd;
  assign w_unused_fwd = ^{forward_en_i, forward_data_i};
  assign w_store_data = read_data_2_i;
`endif

  assign w_pending   = r_ex_mem_write_en | (r_ex_wb_sel == WB_SEL_LOAD);
  assign w_mem_stall = w_pending & ~data_cache_valid_i;

  // EX/MEM: reset/flush clear, external stall or cache wait hold, else load
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_ex_mem_write_en  <= 1'b0;
      r_ex_reg_write_en  <= 1'b0;
      r_ex_wb_sel        <= 2'b00;
      r_ex_write_reg_sel <= 5'd0;
      r_ex_cout          <= 32'd0;
      r_ex_result        <= 32'd0;
      r_ex_store_data    <= 32'd0;
    end else if (!stall_i && !w_mem_stall) begin
      r_ex_mem_write_en  <= mem_write_en_i;
      r_ex_reg_write_en  <= reg_write_en_i;
      r_ex_wb_sel        <= wb_sel_i;
      r_ex_write_reg_sel <= write_reg_sel_i;
      r_ex_cout          <= cout_i;
      r_ex_result        <= result_i;
      r_ex_store_data    <= w_store_data;
    end
  end

  // MEM/WB: a flush still lets the older instruction retire; cache wait inserts bubbles
  always_ff @(posedge clk_i) begin
    if (rst_i || (w_mem_stall && !stall_i && !flush_i)) begin
      r_wb_reg_write_en  <= 1'b0;
      r_wb_sel           <= 2'b00;
      r_wb_write_reg_sel <= 5'd0;
      r_wb_result        <= 32'd0;
      r_wb_cout          <= 32'd0;
      r_wb_read_data     <= 32'd0;
    end else if (flush_i || !stall_i) begin
      r_wb_reg_write_en  <= r_ex_reg_write_en;
      r_wb_sel           <= r_ex_wb_sel;
      r_wb_write_reg_sel <= r_ex_write_reg_sel;
      r_wb_result        <= r_ex_result;
      r_wb_cout          <= r_ex_cout;
      r_wb_read_data     <= data_from_cache_i;
    end
  end

  assign addr_to_cache_o = r_ex_result;
  assign data_to_cache_o = r_ex_store_data;
  assign wr_to_cache_o   = r_ex_mem_write_en;
  assign stall_o         = w_mem_stall;

  assign reg_write_en_o  = r_wb_reg_write_en;
  assign wb_sel_o        = r_wb_sel;
  assign write_reg_sel_o = r_wb_write_reg_sel;
  assign result_o        = r_wb_result;
  assign cout_o          = r_wb_cout;
  assign read_data_o     = r_wb_read_data;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage; expected values are hand-computed.
module tb_memory_stage;

  logic        clk_i = 1'b0;
  logic        rst_i, flush_i, stall_i, mem_write_en_i, reg_write_en_i;
  logic        forward_en_i, data_cache_valid_i;
  logic [1:0]  wb_sel_i;
  logic [4:0]  write_reg_sel_i;
  logic [31:0] cout_i, result_i, read_data_2_i, forward_data_i, data_from_cache_i;
  logic        reg_write_en_o, wr_to_cache_o, stall_o;
  logic [1:0]  wb_sel_o;
  logic [4:0]  write_reg_sel_o;
  logic [31:0] result_o, cout_o, read_data_o, data_to_cache_o, addr_to_cache_o;

  int n_pass = 0;
  int n_total = 0;
  logic [31:0] fwd_exp;

  memory_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .stall_i(stall_i),
    .mem_write_en_i(mem_write_en_i), .reg_write_en_i(reg_write_en_i),
    .forward_en_i(forward_en_i), .data_cache_valid_i(data_cache_valid_i),
    .wb_sel_i(wb_sel_i), .write_reg_sel_i(write_reg_sel_i), .cout_i(cout_i),
    .result_i(result_i), .read_data_2_i(read_data_2_i),
    .forward_data_i(forward_data_i), .data_from_cache_i(data_from_cache_i),
    .reg_write_en_o(reg_write_en_o), .wb_sel_o(wb_sel_o),
    .write_reg_sel_o(write_reg_sel_o), .result_o(result_o), .cout_o(cout_o),
    .read_data_o(read_data_o), .wr_to_cache_o(wr_to_cache_o),
    .data_to_cache_o(data_to_cache_o), .addr_to_cache_o(addr_to_cache_o),
    .stall_o(stall_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1; flush_i = 0; stall_i = 0; mem_write_en_i = 0; reg_write_en_i = 0;
    forward_en_i = 0; data_cache_valid_i = 1; wb_sel_i = 0; write_reg_sel_i = 0;
    cout_i = 0; result_i = 0; read_data_2_i = 0; forward_data_i = 0;
    data_from_cache_i = 0;
`ifdef MEM_STORE_FORWARD_EN
    fwd_exp = 32'h55AA55AA;
`else
    fwd_exp = 32'h00000001;
`endif
    step(); step();
    rst_i = 0;
    check("rst_reg_we", {31'd0, reg_write_en_o}, 0);
    check("rst_result", result_o, 0);
    check("rst_read_data", read_data_o, 0);
    check("rst_wr", {31'd0, wr_to_cache_o}, 0);
    check("rst_addr", addr_to_cache_o, 0);
    check("rst_stall", {31'd0, stall_o}, 0);

    // pass-through, non-load writeback
    reg_write_en_i = 1; wb_sel_i = 2; write_reg_sel_i = 5'h13;
    result_i = 32'hDEADBEEF; cout_i = 32'h1; data_from_cache_i = 32'h12345678;
    step();
    check("load_read_data_1edge", read_data_o, 32'h12345678);
    check("addr_1edge", addr_to_cache_o, 32'hDEADBEEF);
    check("reg_we_not_yet", {31'd0, reg_write_en_o}, 0);
    reg_write_en_i = 0; wb_sel_i = 0; write_reg_sel_i = 0; result_i = 0; cout_i = 0;
    step();
    check("pt_reg_we", {31'd0, reg_write_en_o}, 1);
    check("pt_wb_sel", {30'd0, wb_sel_o}, 2);
    check("pt_wrs", {27'd0, write_reg_sel_o}, 32'h13);
    check("pt_result", result_o, 32'hDEADBEEF);
    check("pt_cout", cout_o, 32'h1);
    check("pt_stall", {31'd0, stall_o}, 0);

    // store, then drop it
    mem_write_en_i = 1; result_i = 32'h100; read_data_2_i = 32'hCAFEF00D;
    step();
    check("st_wr", {31'd0, wr_to_cache_o}, 1);
    check("st_addr", addr_to_cache_o, 32'h100);
    check("st_data", data_to_cache_o, 32'hCAFEF00D);
    mem_write_en_i = 0;
    step();
    check("st_wr_drop", {31'd0, wr_to_cache_o}, 0);

    // store pending, then flush, then long stall
    mem_write_en_i = 1; data_from_cache_i = 32'h0000BEEF;
    step();
    check("st2_wr", {31'd0, wr_to_cache_o}, 1);
    flush_i = 1;
    step();
    flush_i = 0;
    check("fl_wr", {31'd0, wr_to_cache_o}, 0);
    check("fl_addr", addr_to_cache_o, 0);
    check("fl_data", data_to_cache_o, 0);
    check("fl_wb_result", result_o, 32'h100);
    check("fl_wb_read_data", read_data_o, 32'h0000BEEF);
    stall_i = 1; mem_write_en_i = 1; reg_write_en_i = 1; wb_sel_i = 1;
    result_i = 32'h200; read_data_2_i = 32'h77; data_from_cache_i = 32'h99;
    for (int i = 0; i < 20; i++) begin
      step();
      check("stl_wr", {31'd0, wr_to_cache_o}, 0);
      check("stl_addr", addr_to_cache_o, 0);
      check("stl_data", data_to_cache_o, 0);
      check("stl_read_data", read_data_o, 32'h0000BEEF);
      check("stl_reg_we", {31'd0, reg_write_en_o}, 0);
    end
    stall_i = 0;
    step();
    check("rel_addr", addr_to_cache_o, 32'h200);
    check("rel_wr", {31'd0, wr_to_cache_o}, 1);

    // forwarding mux
    mem_write_en_i = 0; reg_write_en_i = 0; wb_sel_i = 0; result_i = 32'h300;
    forward_en_i = 1; forward_data_i = 32'h55AA55AA; read_data_2_i = 32'h1;
    step();
    check("fwd_data", data_to_cache_o, fwd_exp);
    forward_en_i = 0;

    // cache not ready
    data_cache_valid_i = 0;
    mem_write_en_i = 1; reg_write_en_i = 1; write_reg_sel_i = 5'd5;
    result_i = 32'h400; read_data_2_i = 32'hABCD;
    step();
    check("cw_stall", {31'd0, stall_o}, 1);
    check("cw_wr", {31'd0, wr_to_cache_o}, 1);
    mem_write_en_i = 0; reg_write_en_i = 1; write_reg_sel_i = 5'd6; result_i = 32'h500;
    for (int i = 0; i < 2; i++) begin
      step();
      check("cw_hold_addr", addr_to_cache_o, 32'h400);
      check("cw_hold_data", data_to_cache_o, 32'hABCD);
      check("cw_hold_wr", {31'd0, wr_to_cache_o}, 1);
      check("cw_bubble_we", {31'd0, reg_write_en_o}, 0);
      check("cw_bubble_res", result_o, 0);
      check("cw_stall_on", {31'd0, stall_o}, 1);
    end
    data_cache_valid_i = 1;
    #1;
    check("cw_stall_clear", {31'd0, stall_o}, 0);
    step();
    check("cw_retire_we", {31'd0, reg_write_en_o}, 1);
    check("cw_retire_wrs", {27'd0, write_reg_sel_o}, 5);
    check("cw_retire_res", result_o, 32'h400);
    check("cw_next_addr", addr_to_cache_o, 32'h500);
    check("cw_next_wr", {31'd0, wr_to_cache_o}, 0);

    // flush and stall together: flush wins
    mem_write_en_i = 1; result_i = 32'h600;
    step();
    check("fs_wr_set", {31'd0, wr_to_cache_o}, 1);
    flush_i = 1; stall_i = 1;
    step();
    flush_i = 0; stall_i = 0; mem_write_en_i = 0;
    check("fs_wr", {31'd0, wr_to_cache_o}, 0);
    check("fs_addr", addr_to_cache_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
